// File: rtl/fir_sample_packer.sv
// Packs P_SAMPLES dual-channel beats into one wide word for the decimating FIR.
// Accumulator plus output register lets input stream at one beat per clock.
module fir_sample_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int P_SAMPLES  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              in_tvalid,
    output logic                              in_tready,
    input  logic [2*DATA_WIDTH-1:0]           in_tdata,
    input  logic                              in_tlast,
    output logic                              out_tvalid,
    input  logic                              out_tready,
    output logic [2*P_SAMPLES*DATA_WIDTH-1:0] out_tdata,
    output logic                              out_tlast,
    output logic [CNT_WIDTH-1:0]              blk_count
);

    localparam int LANE_W = (P_SAMPLES > 1) ? $clog2(P_SAMPLES) : 1;
    localparam logic [LANE_W-1:0] LAST_CNT = LANE_W'(P_SAMPLES - 1);
    localparam int HALF = P_SAMPLES * DATA_WIDTH;

    logic                  nrst_q;
    logic [LANE_W-1:0]     cnt;
    logic [LANE_W-1:0]     lane_sel;
    logic [DATA_WIDTH-1:0] acc0 [P_SAMPLES];
    logic [DATA_WIDTH-1:0] acc1 [P_SAMPLES];
    logic [DATA_WIDTH-1:0] in_ch0;
    logic [DATA_WIDTH-1:0] in_ch1;
    logic                  at_end;
    logic                  accept;
    logic                  closing;
    logic [2*HALF-1:0]     word_next;

    assign in_ch0   = in_tdata[DATA_WIDTH-1:0];
    assign in_ch1   = in_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign at_end   = (cnt == LAST_CNT);
    assign lane_sel = LAST_CNT - cnt;

    // Closing beats wait for a free output register; others never stall.
    assign in_tready = nrst_q & ((!at_end & !in_tlast) | !out_tvalid | out_tready);
    assign accept    = in_tvalid & in_tready;
    assign closing   = accept & (at_end | in_tlast);

    always_comb begin
        word_next = '0;
        for (int l = 0; l < P_SAMPLES; l++) begin
            if (lane_sel == LANE_W'(l)) begin
                word_next[l*DATA_WIDTH +: DATA_WIDTH]        = in_ch0;
                word_next[HALF + l*DATA_WIDTH +: DATA_WIDTH] = in_ch1;
            end else begin
                word_next[l*DATA_WIDTH +: DATA_WIDTH]        = acc0[l];
                word_next[HALF + l*DATA_WIDTH +: DATA_WIDTH] = acc1[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            nrst_q     <= 1'b0;
            cnt        <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tlast  <= 1'b0;
            blk_count  <= '0;
            for (int l = 0; l < P_SAMPLES; l++) begin
                acc0[l] <= '0;
                acc1[l] <= '0;
            end
        end else begin
            nrst_q <= 1'b1;
            if (closing) begin
                cnt       <= '0;
                out_tdata <= word_next;
                out_tlast <= in_tlast;
                // Cleared so lanes left unfilled by a flush read as zero.
                for (int l = 0; l < P_SAMPLES; l++) begin
                    acc0[l] <= '0;
                    acc1[l] <= '0;
                end
            end else if (accept) begin
                cnt            <= cnt + LANE_W'(1);
                acc0[lane_sel] <= in_ch0;
                acc1[lane_sel] <= in_ch1;
            end

            if (closing) begin
                out_tvalid <= 1'b1;
            end else if (out_tready) begin
                out_tvalid <= 1'b0;
            end

            if (out_tvalid && out_tready) begin
                blk_count <= blk_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_packer.sv
// Directed bench for fir_sample_packer: bursts, streaming, backpressure,
// flush, mid-run reset and blk_count wrap with a 4-bit counter.
module tb_fir_sample_packer;

    localparam int DW = 16;
    localparam int P  = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              nrst;
    logic              in_tvalid;
    logic              in_tready;
    logic [2*DW-1:0]   in_tdata;
    logic              in_tlast;
    logic              out_tvalid;
    logic              out_tready;
    logic [2*P*DW-1:0] out_tdata;
    logic              out_tlast;
    logic [CW-1:0]     blk_count;

    int checks = 0;
    int errors = 0;

    fir_sample_packer #(.DATA_WIDTH(DW), .P_SAMPLES(P), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .blk_count  (blk_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] c0, input logic [15:0] c1, input logic last);
        in_tvalid = 1'b1;
        in_tdata  = {c1, c0};
        in_tlast  = last;
        tick();
    endtask

    task automatic idle();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tdata  = '0;
    endtask

    initial begin
        int accepted;
        int words;
        int last_i;
        int drops;

        nrst       = 1'b0;
        out_tready = 1'b1;
        idle();
        tick();
        tick();
        check("rst_out_tvalid", 256'(out_tvalid), 256'(0));
        check("rst_out_tdata",  out_tdata, 256'(0));
        check("rst_out_tlast",  256'(out_tlast), 256'(0));
        check("rst_blk_count",  256'(blk_count), 256'(0));
        check("rst_in_tready",  256'(in_tready), 256'(0));
        nrst = 1'b1;
        tick();
        check("post_rst_in_tready", 256'(in_tready), 256'(1));

        // Burst of one full block
        for (int k = 1; k <= 8; k++) beat(16'(k), 16'(16'h0100 + k), 1'b0);
        idle();
        check("burst_tvalid", 256'(out_tvalid), 256'(1));
        check("burst_tlast", 256'(out_tlast), 256'(0));
        check("burst_word", out_tdata,
              {16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h0108,
               16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008});
        tick();
        check("burst_blk_count", 256'(blk_count), 256'(1));
        check("burst_drained", 256'(out_tvalid), 256'(0));

        // Back-to-back stream of 64 beats
        words = 0;
        last_i = 0;
        drops = 0;
        for (int i = 0; i < 66; i++) begin
            if (i < 64) begin
                in_tvalid = 1'b1;
                in_tdata  = {16'(16'h1000 + i), 16'(i)};
                in_tlast  = 1'b0;
                #1;
                if (!in_tready) drops++;
            end else begin
                idle();
            end
            tick();
            if (out_tvalid) begin
                words++;
                if (words > 1) check("stream_gap", 256'(i - last_i), 256'(8));
                check("stream_lane0", 256'(out_tdata[15:0]), 256'(i));
                check("stream_lane7", 256'(out_tdata[127:112]), 256'(i - 7));
                last_i = i;
            end
        end
        check("stream_ready_drops", 256'(drops), 256'(0));
        check("stream_words", 256'(words), 256'(8));
        check("stream_blk_count", 256'(blk_count), 256'(9));

        // Backpressure: 15 beats then stall on the closing beat
        out_tready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 20; c++) begin
            in_tvalid = 1'b1;
            in_tdata  = {16'(16'h0300 + accepted + 1), 16'(16'h0200 + accepted + 1)};
            in_tlast  = 1'b0;
            #1;
            if (in_tready) accepted++;
            tick();
        end
        #1;
        check("bp_accepted", 256'(accepted), 256'(15));
        check("bp_stalled", 256'(in_tready), 256'(0));
        check("bp_held_lane0", 256'(out_tdata[15:0]), 256'(16'h0208));
        out_tready = 1'b1;
        #1;
        check("bp_ready_comb", 256'(in_tready), 256'(1));
        tick();
        out_tready = 1'b0;
        idle();
        check("bp_word2_valid", 256'(out_tvalid), 256'(1));
        check("bp_word2_lane0", 256'(out_tdata[15:0]), 256'(16'h0210));
        check("bp_word2_lane7", 256'(out_tdata[127:112]), 256'(16'h0209));
        check("bp_word2_ch1_lane0", 256'(out_tdata[143:128]), 256'(16'h0310));
        check("bp_blk_count", 256'(blk_count), 256'(10));
        out_tready = 1'b1;
        tick();
        check("bp_drain_count", 256'(blk_count), 256'(11));
        check("bp_drain_valid", 256'(out_tvalid), 256'(0));

        // Flush after three beats, then a full block closed by tlast
        beat(16'h000A, 16'h001A, 1'b0);
        beat(16'h000B, 16'h001B, 1'b0);
        beat(16'h000C, 16'h001C, 1'b1);
        check("flush_valid", 256'(out_tvalid), 256'(1));
        check("flush_tlast", 256'(out_tlast), 256'(1));
        check("flush_word", out_tdata,
              {16'h001A, 16'h001B, 16'h001C, 80'h0, 16'h000A, 16'h000B, 16'h000C, 80'h0});
        for (int k = 1; k <= 8; k++) beat(16'(16'h0020 + k), 16'(16'h0030 + k), k == 8);
        idle();
        check("full_tlast", 256'(out_tlast), 256'(1));
        check("full_after_flush_word", out_tdata,
              {16'h0031, 16'h0032, 16'h0033, 16'h0034, 16'h0035, 16'h0036, 16'h0037, 16'h0038,
               16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h0025, 16'h0026, 16'h0027, 16'h0028});
        tick();
        check("flush_blk_count", 256'(blk_count), 256'(13));

        // Reset with a held word and a partial block
        out_tready = 1'b0;
        for (int k = 1; k <= 13; k++) beat(16'(16'h0050 + k), 16'(16'h0090 + k), 1'b0);
        idle();
        check("pre_rst_held", 256'(out_tvalid), 256'(1));
        nrst = 1'b0;
        tick();
        check("mid_rst_tvalid", 256'(out_tvalid), 256'(0));
        check("mid_rst_blk_count", 256'(blk_count), 256'(0));
        check("mid_rst_tdata", out_tdata, 256'(0));
        check("mid_rst_in_tready", 256'(in_tready), 256'(0));
        nrst = 1'b1;
        tick();
        check("mid_rst_ready_back", 256'(in_tready), 256'(1));
        out_tready = 1'b1;
        for (int k = 1; k <= 8; k++) beat(16'(16'h0060 + k), 16'(16'h0070 + k), 1'b0);
        idle();
        check("clean_word", out_tdata,
              {16'h0071, 16'h0072, 16'h0073, 16'h0074, 16'h0075, 16'h0076, 16'h0077, 16'h0078,
               16'h0061, 16'h0062, 16'h0063, 16'h0064, 16'h0065, 16'h0066, 16'h0067, 16'h0068});
        check("clean_tlast", 256'(out_tlast), 256'(0));
        tick();
        check("clean_blk_count", 256'(blk_count), 256'(1));

        // 17 words through a 4-bit counter wraps to 1
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        for (int k = 0; k < 17 * 8; k++) beat(16'(k), 16'(k), 1'b0);
        idle();
        tick();
        tick();
        check("wrap_blk_count", 256'(blk_count), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
